// File: rtl/nbit_serial_subtractor.sv
// ---------------------------------------------------------------------------
// nbit_serial_subtractor
//
// Bit-serial N-bit subtractor: diff = a - b - b_in, processed LSB first with a
// single full-subtractor stage, one bit per clock. An operation takes N SHIFT
// cycles followed by one DONE cycle, so a new operation can start every N+1
// cycles.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   operation request, accepted in IDLE (and in DONE, which allows
//               back-to-back operations with start held high)
//   a      in   [N-1:0] minuend, captured at the accept edge
//   b      in   [N-1:0] subtrahend, captured at the accept edge
//   b_in   in   borrow-in, captured at the accept edge
//   busy   out  high in SHIFT and DONE
//   done   out  single-cycle pulse; diff/b_out/ovf hold the new result
//   diff   out  [N-1:0] a - b - b_in modulo 2^N
//   b_out  out  borrow-out (unsigned a < b + b_in)
//   ovf    out  two's complement overflow of a - b - b_in
// ---------------------------------------------------------------------------
module nbit_serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         b_out,
    output logic         ovf
);

    // Counter indexes bits 0..N-1; N >= 2 keeps the width at least one bit.
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [N-1:0]    a_sr;
    logic [N-1:0]    b_sr;
    logic [N-1:0]    res_sr;
    logic            borrow;
    logic [CW-1:0]   cnt;
    logic            a_msb;
    logic            b_msb;

    logic            accept;
    logic            last;
    logic            d_bit;
    logic            borrow_next;

    // DONE also accepts start: the next operation overlaps the result cycle,
    // which is what gives one operation every N+1 cycles.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == SHIFT) && (cnt == CW'(N - 1));

    // Full subtractor on the current LSBs of the operand shift registers.
    assign d_bit       = a_sr[0] ^ b_sr[0] ^ borrow;
    assign borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (last)   next_state = DONE;
            DONE:    next_state = accept ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // -----------------------------------------------------------------------
    // Datapath: operand capture, serial subtraction, result load
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            b_out  <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= b_in;
            cnt    <= '0;
            a_msb  <= a[N-1];
            b_msb  <= b[N-1];
        end else if (state == SHIFT) begin
            // Result fills from the MSB side so bit 0 ends up at the bottom
            // after N shifts.
            res_sr <= {d_bit, res_sr[N-1:1]};
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            borrow <= borrow_next;
            cnt    <= cnt + 1'b1;
            if (last) begin
                diff  <= {d_bit, res_sr[N-1:1]};
                b_out <= borrow_next;
                // Overflow only when operand signs differ and the result sign
                // disagrees with the minuend.
                ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_nbit_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_nbit_serial_subtractor
//
// Directed tests of the bit-serial subtractor with N=4: reset values, signed
// and unsigned boundary cases, start ignored mid-operation, reset abort,
// back-to-back throughput, and an exhaustive sweep of all operand triples.
// ---------------------------------------------------------------------------
module tb_nbit_serial_subtractor;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         b_out;
    logic         ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    nbit_serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: (N+1)-bit unsigned subtraction plus signed overflow.
    function automatic logic [N+1:0] model(input logic [N-1:0] ma,
                                           input logic [N-1:0] mb,
                                           input logic mbin);
        logic [N:0] r;
        int         s;
        r = {1'b0, ma} - {1'b0, mb} - {{N{1'b0}}, mbin};
        s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        model = {(s < -(2 ** (N - 1))) || (s > 2 ** (N - 1) - 1), r};
    endfunction

    // Drives one start pulse and waits (bounded) for done. lat is the number
    // of rising edges after the accept edge until done is visible; 99 means
    // done never came.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input logic tbin, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; b_in = tbin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (diff !== 4'b0000) $display("FAIL reset_diff: got %b expected 0000", diff); else pass_cnt++;
        total_cnt++; if (b_out !== 1'b0) $display("FAIL reset_b_out: got %b expected 0", b_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_no_start: busy=%b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_basic;
        int lat;
        // 10 - 5: unsigned no borrow; signed -6 - 5 = -11 overflows.
        run_op(4'b1010, 4'b0101, 1'b0, lat);
        total_cnt++; if (lat !== N) $display("FAIL basic_latency: got %0d expected %0d", lat, N); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_in_done: got %b expected 1", busy); else pass_cnt++;
        total_cnt++; if (diff !== 4'b0101) $display("FAIL basic_diff: got %b expected 0101", diff); else pass_cnt++;
        total_cnt++; if (b_out !== 1'b0) $display("FAIL basic_b_out: got %b expected 0", b_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b1) $display("FAIL basic_ovf: got %b expected 1", ovf); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_single: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle_after: busy=%b expected 0", busy); else pass_cnt++;
        // Result holds while idle and through the SHIFT phase of the next op.
        repeat (3) @(negedge clk);
        a = 4'b0000; b = 4'b0001; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (diff !== 4'b0101) $display("FAIL basic_diff_hold: got %b expected 0101", diff); else pass_cnt++;
        repeat (8) @(negedge clk);
        total_cnt++; if (diff !== 4'b1111 || b_out !== 1'b1) $display("FAIL hold_next_result: got %b/%b expected 1111/1", diff, b_out); else pass_cnt++;
    endtask

    task automatic test_overflow;
        int lat;
        // 5 - (-6) = 11 exceeds +7.
        run_op(4'b0101, 4'b1010, 1'b0, lat);
        total_cnt++; if (lat !== N) $display("FAIL ovf_latency: got %0d expected %0d", lat, N); else pass_cnt++;
        total_cnt++; if (diff !== 4'b1011) $display("FAIL ovf_diff: got %b expected 1011", diff); else pass_cnt++;
        total_cnt++; if (b_out !== 1'b1) $display("FAIL ovf_b_out: got %b expected 1", b_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_ovf: got %b expected 1", ovf); else pass_cnt++;
    endtask

    task automatic test_borrow_chain;
        int lat;
        // 15 - 15 - 1 = -1: borrow ripples through every bit.
        run_op(4'b1111, 4'b1111, 1'b1, lat);
        total_cnt++; if (diff !== 4'b1111) $display("FAIL chain_diff: got %b expected 1111", diff); else pass_cnt++;
        total_cnt++; if (b_out !== 1'b1) $display("FAIL chain_b_out: got %b expected 1", b_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0) $display("FAIL chain_ovf: got %b expected 0", ovf); else pass_cnt++;
        // 11 - 3 - 1 = 7; signed -5 - 3 - 1 = -9 overflows.
        run_op(4'b1011, 4'b0011, 1'b1, lat);
        total_cnt++; if (diff !== 4'b0111) $display("FAIL bin_diff: got %b expected 0111", diff); else pass_cnt++;
        total_cnt++; if (b_out !== 1'b0) $display("FAIL bin_b_out: got %b expected 0", b_out); else pass_cnt++;
        total_cnt++; if (ovf !== 1'b1) $display("FAIL bin_ovf: got %b expected 1", ovf); else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        int dones = 0;
        int lat;
        @(negedge clk);
        a = 4'b0110; b = 4'b0001; b_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);            // first SHIFT cycle
        start = 1'b0;
        @(negedge clk);            // second SHIFT cycle
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_flags: busy=%b done=%b expected 0/0", busy, done); else pass_cnt++;
        total_cnt++; if (diff !== 4'b0000 || b_out !== 1'b0 || ovf !== 1'b0) $display("FAIL midrst_outputs: got %b/%b/%b expected 0000/0/0", diff, b_out, ovf); else pass_cnt++;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        total_cnt++; if (dones !== 0) $display("FAIL midrst_no_done: got %0d done pulses expected 0", dones); else pass_cnt++;
        run_op(4'b0110, 4'b0001, 1'b0, lat);
        total_cnt++; if (lat !== N || diff !== 4'b0101 || b_out !== 1'b0) $display("FAIL midrst_recover: lat=%0d diff=%b b_out=%b expected %0d/0101/0", lat, diff, b_out, N); else pass_cnt++;
    endtask

    task automatic test_ignore_start;
        int dones = 0;
        @(negedge clk);
        a = 4'b0011; b = 4'b0011; b_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 4'b1111; b = 4'b0001;
        @(negedge clk);
        start = 1'b1; a = 4'b1000; b = 4'b0111; b_in = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 4'b0001; b = 4'b1110;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                dones++;
                total_cnt++; if (diff !== 4'b0000 || b_out !== 1'b0 || ovf !== 1'b0) $display("FAIL ignore_result: got %b/%b/%b expected 0000/0/0", diff, b_out, ovf); else pass_cnt++;
            end
            @(negedge clk);
        end
        total_cnt++; if (dones !== 1) $display("FAIL ignore_done_count: got %0d expected 1", dones); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] va [3];
        logic [N-1:0] vb [3];
        logic         vi [3];
        logic [N+1:0] exp_v;
        int           done_cyc [3];
        bit           seen;
        va[0] = 4'b0111; vb[0] = 4'b0010; vi[0] = 1'b0;   // 7-2   = 5
        va[1] = 4'b0000; vb[1] = 4'b0001; vi[1] = 1'b1;   // 0-1-1 = -2
        va[2] = 4'b1000; vb[2] = 4'b0001; vi[2] = 1'b0;   // -8-1 overflows
        @(negedge clk);
        a = va[0]; b = vb[0]; b_in = vi[0]; start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);        // accept edge of op j
            @(negedge clk);
            if (j < 2) begin
                a = va[j+1]; b = vb[j+1]; b_in = vi[j+1];
            end else begin
                start = 1'b0; a = 4'b1111; b = 4'b1111;
            end
            seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            done_cyc[j] = cyc;
            exp_v = model(va[j], vb[j], vi[j]);
            total_cnt++; if (!seen || {ovf, b_out, diff} !== exp_v) $display("FAIL b2b_result_%0d: got seen=%b %b/%b/%b expected %b/%b/%b", j, seen, ovf, b_out, diff, exp_v[N+1], exp_v[N], exp_v[N-1:0]); else pass_cnt++;
            if (j > 0) begin
                total_cnt++; if (done_cyc[j] - done_cyc[j-1] !== N + 1) $display("FAIL b2b_spacing_%0d: got %0d expected %0d", j, done_cyc[j] - done_cyc[j-1], N + 1); else pass_cnt++;
            end
        end
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle_after: busy=%b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_exhaustive;
        int           lat;
        int           errs = 0;
        logic [N+1:0] exp_v;
        for (int ia = 0; ia < 2 ** N; ia++) begin
            for (int ib = 0; ib < 2 ** N; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_op(N'(ia), N'(ib), 1'(ic), lat);
                    exp_v = model(N'(ia), N'(ib), 1'(ic));
                    total_cnt++;
                    if (lat !== N || {ovf, b_out, diff} !== exp_v) begin
                        errs++;
                        if (errs <= 10) $display("FAIL exhaustive a=%0d b=%0d bin=%0d: lat=%0d got %b/%b/%b expected %0d/%b/%b/%b", ia, ib, ic, lat, ovf, b_out, diff, N, exp_v[N+1], exp_v[N], exp_v[N-1:0]);
                    end else begin
                        pass_cnt++;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_borrow_chain();
        test_mid_reset();
        test_ignore_start();
        test_back_to_back();
        test_exhaustive();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
